// File: rtl/disp_pkg.sv
// ============================================================================
//  Module   : disp_pkg
//  Brief    : Shared display definitions: converter FSM states and BCD limits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_OVF   = 2'd3
    } state_t;

    localparam int unsigned C_BCD_MAX  = 9999;
    localparam logic [15:0] C_OVF_CODE = 16'hEEEE;

endpackage : disp_pkg

`default_nettype wire

// File: rtl/disp_bcd_conv_if.sv
// ============================================================================
//  Module   : disp_bcd_conv_if
//  Brief    : Input handshake and display-side result bundle of the converter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface disp_bcd_conv_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] bin_in;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      disp_num;
    logic             done;
    logic             ovf;

    modport master (
        output bin_in, in_valid,
        input  in_ready, disp_num, done, ovf
    );

    modport slave (
        input  bin_in, in_valid,
        output in_ready, disp_num, done, ovf
    );
endinterface : disp_bcd_conv_if

`default_nettype wire

// File: rtl/bcd_adj_nibble.sv
// ============================================================================
//  Module   : bcd_adj_nibble
//  Brief    : Combinational double-dabble digit correction (>= 5 gets +3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_adj_nibble (
    input  wire logic [3:0] nib_in,
    output logic      [3:0] nib_out
);
    // Pre-shift digit is at most 9, so the 4-bit sum never wraps.
    assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;
endmodule : bcd_adj_nibble

`default_nettype wire

// File: rtl/disp_bcd_conv.sv
// ============================================================================
//  Module   : disp_bcd_conv
//  Brief    : Iterative binary-to-packed-BCD converter feeding the 4-digit display.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module disp_bcd_conv
    import disp_pkg::*;
#(
    parameter int          BIN_W    = 14,
    parameter logic [15:0] OVF_CODE = C_OVF_CODE
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    disp_bcd_conv_if.slave      bus
);

    localparam logic [13:0] C_MAX_W = 14'(C_BCD_MAX);
    localparam logic [3:0]  C_CNT_INIT = 4'(BIN_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIN_W-1:0] r_bin;
    logic [15:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic [15:0]      r_disp;
    logic             r_done;
    logic             r_ovf;

    logic             w_accept;
    logic             w_in_ovf;
    logic [13:0]      w_bin_ext;
    logic [15:0]      w_adj;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_bin_ext = 14'(bus.bin_in);
    assign w_in_ovf  = (w_bin_ext > C_MAX_W);

    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        bcd_adj_nibble u_adj (
            .nib_in  (r_bcd[gi*4 +: 4]),
            .nib_out (w_adj[gi*4 +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_in_ovf ? ST_OVF : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  w_state_nxt = ST_IDLE;
            ST_OVF:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Scratch registers churn during SHIFT; only LOAD/OVF touch the display word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_disp <= '0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bin <= bus.bin_in;
                        r_bcd <= '0;
                        r_cnt <= C_CNT_INIT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_adj[14:0], r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_LOAD: begin
                    r_disp <= r_bcd;
                    r_ovf  <= 1'b0;
                    r_done <= 1'b1;
                end
                ST_OVF: begin
                    r_disp <= OVF_CODE;
                    r_ovf  <= 1'b1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = (r_state == ST_IDLE);
    assign bus.disp_num = r_disp;
    assign bus.done     = r_done;
    assign bus.ovf      = r_ovf;

endmodule : disp_bcd_conv

`default_nettype wire

// File: doc/disp_bcd_conv.md
Name: disp_bcd_conv

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment driver.
- Accepts an unsigned binary value over a valid/ready handshake.
- Converts it iteratively using shift-and-add-3 (double dabble), one bit per cycle.
- Presents a stable 16-bit packed-BCD word (four nibbles, most-significant digit in [15:12]) on disp_num.
- Lets debug counters (poll counts, error counts, stick values) display in decimal instead of hex.

Parameters:
- BIN_W, 14: width of binary input; legal range 4..14.
- OVF_CODE, 16'hEEEE: value driven on disp_num when the input exceeds 9999.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- bin_in  input  BIN_W  binary value to convert; sampled only on accept.
- in_valid  input  1  bin_in holds a value to convert.
- in_ready  output  1  converter idle and able to accept.
- disp_num  output  16  packed BCD result; feeds the display driver.
- done  output  1  one-cycle pulse when disp_num has just been updated.
- ovf  output  1  sticky-per-result flag: last accepted value was > 9999.

Behaviour:
- Reset (asynchronous, active-low, all flops):
  - disp_num = 16'h0000, done = 0, ovf = 0, in_ready = 1.
  - FSM = IDLE, iteration counter = 0.
- Accept: a transfer occurs when in_valid && in_ready on a rising edge of clk.
  - bin_in is captured into a BIN_W shift register.
  - The 16-bit BCD scratch register is cleared.
- FSM states:
  - IDLE: in_ready = 1.
    - On accept with bin_in > 9999: go to OVF.
    - On any other accept: go to SHIFT with counter = BIN_W-1.
  - SHIFT: in_ready = 0. Each cycle:
    - Every BCD nibble >= 5 gets +3. All nibbles are adjusted combinationally from the current value.
    - Then {bcd, bin} shifts left by 1.
    - Counter decrements. When the counter is 0 at the end of a shift, go to LOAD.
  - LOAD: in_ready = 0.
    - disp_num <= scratch, ovf <= 0, done <= 1 for this one cycle.
    - Go to IDLE.
  - OVF: in_ready = 0.
    - disp_num <= OVF_CODE, ovf <= 1, done <= 1.
    - Go to IDLE.
- Latency:
  - Normal conversion: accept edge to done high = BIN_W+1 cycles. For BIN_W = 14: 14 SHIFT cycles + 1 LOAD cycle.
  - Overflow: 1 cycle.
  - Next accept is possible the cycle after done, i.e. in_ready is high in the cycle following LOAD/OVF.
- disp_num is held constant between done pulses. The display never shows intermediate shift values.
- Adjustment width rules:
  - Each nibble is adjusted independently with a 4-bit add. No carry between nibbles; a pre-shift nibble is always <= 9, so nibble+3 <= 12.
  - Only the low 4 nibbles exist. Since the input is <= 9999, no fifth digit is ever needed.
- The 9999 comparison is done on bin_in zero-extended to 14 bits. For BIN_W < 14, overflow is impossible and OVF is unreachable.
- in_valid held high continuously: a new conversion is accepted every BIN_W+2 cycles. Values are never dropped while in_ready = 1.
- Changes on bin_in or in_valid while busy are ignored. There is no queue.
- Reset asserted mid-conversion:
  - Returns immediately to reset values.
  - disp_num goes to 0, not to a partial result.
  - No done pulse.

Decomposition:
- Shared display package (disp_pkg) holds:
  - the FSM state enum (IDLE, SHIFT, LOAD, OVF);
  - the constant BCD_MAX = 9999;
  - the default OVF_CODE.
- One sub-module: bcd_adj_nibble, a purely combinational 4-bit "if >= 5 add 3", instantiated 4 times.

Test Plan:
- Reset state: assert rst_n low mid-SHIFT -> disp_num = 16'h0000, in_ready = 1, done never pulses; after release, accepting 1234 -> disp_num = 16'h1234.
- Basic conversions: 0 -> 16'h0000; 9999 -> 16'h9999; 1000 -> 16'h1000.
  - done rises exactly 15 cycles after the accept edge (BIN_W = 14).
- Overflow: 10000 -> disp_num = 16'hEEEE, ovf = 1, done 1 cycle after accept; then 42 -> 16'h0042, ovf = 0.
- Back-to-back: in_valid held high with 17, 256, 8191 -> three done pulses spaced 16 cycles apart, values 16'h0017, 16'h0256, 16'h8191.
  - Input changes during busy cycles are ignored.
- Stability: sample disp_num every cycle during a conversion of 5555 started after 16'h1234 -> reads 16'h1234 until the done cycle, then 16'h5555.
- Exhaustive sweep 0..16383 with a reference model:
  - disp_num matches decimal digits for all values <= 9999;
  - disp_num = OVF_CODE and ovf = 1 for all values above 9999.
